// File: rtl/banked_register_file_if.sv
// Control/datapath bundle of the banked register file: ACC path, two read
// ports, status update, pointer increments and the context-switch handshake.
interface banked_register_file_if #(
   parameter int DATA_W         = 8,
   parameter int I_ADDR_WIDTH   = 12,
   parameter int D_ADDR_WIDTH   = 12,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int BANK_W         = 1
);
   logic [DATA_W-1:0]         acc_out;
   logic [DATA_W-1:0]         acc_in;
   logic                      acc_write_enable;
   logic                      read_get_to_acc;
   logic                      write_put_acc;
   logic [REG_ADDR_WIDTH-1:0] reg_addr;
   logic                      read_data_output_enable;
   logic [REG_ADDR_WIDTH-1:0] rd_b_addr;
   logic [DATA_W-1:0]         rd_b_data;
   logic                      status_write_enable;
   logic                      zero_flag;
   logic                      positive_flag;
   logic                      carry_flag;
   logic                      overflow_flag;
   logic                      dptr_inc;
   logic                      iptr_inc;
   logic                      ctx_req;
   logic [BANK_W-1:0]         ctx_bank;
   logic                      ctx_copy_acc;
   logic                      ctx_ready;
   logic                      ctx_ack;
   logic                      ctx_err;
   logic [BANK_W-1:0]         cur_bank;
   logic [D_ADDR_WIDTH-1:0]   dmar;
   logic [I_ADDR_WIDTH-1:0]   imar;

   modport master (
      input  acc_out, rd_b_data, ctx_ready, ctx_ack, ctx_err, cur_bank, dmar, imar,
      output acc_in, acc_write_enable, read_get_to_acc, write_put_acc, reg_addr,
             read_data_output_enable, rd_b_addr, status_write_enable, zero_flag,
             positive_flag, carry_flag, overflow_flag, dptr_inc, iptr_inc,
             ctx_req, ctx_bank, ctx_copy_acc
   );

   modport slave (
      output acc_out, rd_b_data, ctx_ready, ctx_ack, ctx_err, cur_bank, dmar, imar,
      input  acc_in, acc_write_enable, read_get_to_acc, write_put_acc, reg_addr,
             read_data_output_enable, rd_b_addr, status_write_enable, zero_flag,
             positive_flag, carry_flag, overflow_flag, dptr_inc, iptr_inc,
             ctx_req, ctx_bank, ctx_copy_acc
   );
endinterface

// File: rtl/banked_register_file.sv
// CPU register file with NUM_BANKS copies of GPR/ACC/STATUS, shared address
// pointers with post-increment, two read ports and a context-switch FSM.
module banked_register_file #(
   parameter int DATA_W         = 8,
   parameter int I_ADDR_WIDTH   = 12,
   parameter int D_ADDR_WIDTH   = 12,
   parameter int NUM_GPR        = 8,
   parameter int NUM_BANKS      = 2,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   banked_register_file_if.slave bus,
   output tri   [DATA_W-1:0]   read_data
);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int DBAR_W = D_ADDR_WIDTH - DATA_W;
   localparam int IBAR_W = I_ADDR_WIDTH - DATA_W;
   localparam int GPR_AW = $clog2(NUM_GPR);

   localparam logic [REG_ADDR_WIDTH-1:0] A_ACC    = REG_ADDR_WIDTH'(8);
   localparam logic [REG_ADDR_WIDTH-1:0] A_DBAR   = REG_ADDR_WIDTH'(9);
   localparam logic [REG_ADDR_WIDTH-1:0] A_DOFF   = REG_ADDR_WIDTH'(10);
   localparam logic [REG_ADDR_WIDTH-1:0] A_IBAR   = REG_ADDR_WIDTH'(11);
   localparam logic [REG_ADDR_WIDTH-1:0] A_IOFF   = REG_ADDR_WIDTH'(12);
   localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS = REG_ADDR_WIDTH'(13);
   localparam logic [REG_ADDR_WIDTH-1:0] A_BANK   = REG_ADDR_WIDTH'(14);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SWITCH = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   logic [NUM_BANKS-1:0][NUM_GPR-1:0][DATA_W-1:0] gpr;
   logic [NUM_BANKS-1:0][DATA_W-1:0]              acc;
   logic [NUM_BANKS-1:0][DATA_W-1:0]              status;
   logic [D_ADDR_WIDTH-1:0]                       dptr;
   logic [I_ADDR_WIDTH-1:0]                       iptr;

   logic [1:0]        state;
   logic [BANK_W-1:0] cur_bank;
   logic [BANK_W-1:0] tgt_bank;
   logic              tgt_copy;
   logic              err_q;

   logic [DATA_W-1:0] acc_cur;
   logic [DATA_W-1:0] port_a;
   logic [DATA_W-1:0] acc_src;
   logic [DATA_W-1:0] st_next;
   logic              put_gpr, put_dbar, put_doff, put_ibar, put_ioff, put_st;
   logic              copy_now;

   function automatic logic [DATA_W-1:0] rd_mux(input logic [REG_ADDR_WIDTH-1:0] a);
      logic [DATA_W-1:0] d;
      d = '0;
      if (32'(a) < NUM_GPR) d = gpr[cur_bank][a[GPR_AW-1:0]];
      else begin
         case (a)
            A_ACC:    d = acc[cur_bank];
            A_DBAR:   d = DATA_W'(dptr[D_ADDR_WIDTH-1:DATA_W]);
            A_DOFF:   d = dptr[DATA_W-1:0];
            A_IBAR:   d = DATA_W'(iptr[I_ADDR_WIDTH-1:DATA_W]);
            A_IOFF:   d = iptr[DATA_W-1:0];
            A_STATUS: d = status[cur_bank];
            A_BANK:   d = DATA_W'(cur_bank);
            default:  d = '0;
         endcase
      end
      return d;
   endfunction

   always_comb begin
      acc_cur = acc[cur_bank];
      port_a  = rd_mux(bus.reg_addr);
      acc_src = bus.read_get_to_acc ? port_a : bus.acc_in;
      put_gpr  = bus.write_put_acc && (32'(bus.reg_addr) < NUM_GPR);
      put_dbar = bus.write_put_acc && (bus.reg_addr == A_DBAR);
      put_doff = bus.write_put_acc && (bus.reg_addr == A_DOFF);
      put_ibar = bus.write_put_acc && (bus.reg_addr == A_IBAR);
      put_ioff = bus.write_put_acc && (bus.reg_addr == A_IOFF);
      put_st   = bus.write_put_acc && (bus.reg_addr == A_STATUS);
      // ALU flags win over a same-cycle PUT on the low nibble only
      st_next = status[cur_bank];
      if (put_st) st_next = acc_cur;
      if (bus.status_write_enable)
         st_next[3:0] = {bus.overflow_flag, bus.carry_flag, bus.positive_flag, bus.zero_flag};
      copy_now = (state == ST_SWITCH) && tgt_copy;
   end

   assign bus.acc_out   = acc_cur;
   assign bus.rd_b_data = rd_mux(bus.rd_b_addr);
   assign read_data     = bus.read_data_output_enable ? port_a : 'z;
   assign bus.dmar      = dptr;
   assign bus.imar      = iptr;
   assign bus.cur_bank  = cur_bank;
   assign bus.ctx_ready = (state == ST_IDLE);
   assign bus.ctx_ack   = (state == ST_ACK);
   assign bus.ctx_err   = (state == ST_ACK) && err_q;

   // Writes go to cur_bank, which only changes at the end of SWITCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gpr    <= '0;
         acc    <= '0;
         status <= {NUM_BANKS{DATA_W'(8'h03)}};
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (b == int'(cur_bank)) begin
               if (put_gpr) gpr[b][bus.reg_addr[GPR_AW-1:0]] <= acc_cur;
               if (bus.acc_write_enable) acc[b] <= acc_src;
               status[b] <= st_next;
            end
            if (copy_now && (b == int'(tgt_bank))) acc[b] <= acc_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dptr <= '0;
         iptr <= '0;
      end else begin
         if (put_dbar)          dptr[D_ADDR_WIDTH-1:DATA_W] <= acc_cur[DBAR_W-1:0];
         else if (put_doff)     dptr[DATA_W-1:0]            <= acc_cur;
         else if (bus.dptr_inc) dptr <= dptr + D_ADDR_WIDTH'(1);
         if (put_ibar)          iptr[I_ADDR_WIDTH-1:DATA_W] <= acc_cur[IBAR_W-1:0];
         else if (put_ioff)     iptr[DATA_W-1:0]            <= acc_cur;
         else if (bus.iptr_inc) iptr <= iptr + I_ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cur_bank <= '0;
         tgt_bank <= '0;
         tgt_copy <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.ctx_req) begin
               tgt_bank <= bus.ctx_bank;
               tgt_copy <= bus.ctx_copy_acc;
               // invalid or same bank: answer straight away without switching
               if (32'(bus.ctx_bank) >= NUM_BANKS) begin
                  err_q <= 1'b1;
                  state <= ST_ACK;
               end else if (bus.ctx_bank == cur_bank) begin
                  err_q <= 1'b0;
                  state <= ST_ACK;
               end else begin
                  err_q <= 1'b0;
                  state <= ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               cur_bank <= tgt_bank;
               state    <= ST_ACK;
            end
            ST_ACK: begin
               err_q <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_banked_register_file.sv
// Random + directed bench: a spec-level model predicts reads and context acks,
// expectations are queued and a negedge monitor compares them.
module tb_banked_register_file;
   localparam int DW = 8;
   localparam int NB = 3;
   localparam int BW = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   wire [DW-1:0] read_data;

   banked_register_file_if #(.DATA_W(DW), .I_ADDR_WIDTH(12), .D_ADDR_WIDTH(12),
                             .REG_ADDR_WIDTH(4), .BANK_W(BW)) bus ();

   banked_register_file #(.DATA_W(DW), .I_ADDR_WIDTH(12), .D_ADDR_WIDTH(12),
                          .NUM_GPR(8), .NUM_BANKS(NB), .REG_ADDR_WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .read_data(read_data));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int addr; logic [7:0] d; logic [7:0] acc; logic [11:0] dm; logic [11:0] im; logic [1:0] bank;
   } rexp_t;
   typedef struct { bit err; logic [1:0] bank; int cyc; } aexp_t;
   rexp_t rq[$];
   aexp_t aq[$];
   bit chk_vld = 1'b0;

   // reference model
   logic [7:0] m_gpr [NB][8];
   logic [7:0] m_acc [NB];
   logic [7:0] m_st  [NB];
   int m_dptr, m_iptr, m_bank;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic m_reset();
      for (int b = 0; b < NB; b++) begin
         for (int r = 0; r < 8; r++) m_gpr[b][r] = 8'h00;
         m_acc[b] = 8'h00;
         m_st[b]  = 8'h03;
      end
      m_dptr = 0; m_iptr = 0; m_bank = 0;
   endtask

   function automatic logic [7:0] m_read(input int a);
      if (a < 8) return m_gpr[m_bank][a];
      case (a)
         8:  return m_acc[m_bank];
         9:  return 8'(m_dptr / 256);
         10: return 8'(m_dptr % 256);
         11: return 8'(m_iptr / 256);
         12: return 8'(m_iptr % 256);
         13: return m_st[m_bank];
         14: return 8'(m_bank);
         default: return 8'h00;
      endcase
   endfunction

   task automatic idle();
      bus.acc_in = '0; bus.acc_write_enable = 0; bus.read_get_to_acc = 0;
      bus.write_put_acc = 0; bus.reg_addr = '0; bus.read_data_output_enable = 0;
      bus.rd_b_addr = '0; bus.status_write_enable = 0; bus.zero_flag = 0;
      bus.positive_flag = 0; bus.carry_flag = 0; bus.overflow_flag = 0;
      bus.dptr_inc = 0; bus.iptr_inc = 0; bus.ctx_req = 0; bus.ctx_bank = '0;
      bus.ctx_copy_acc = 0;
   endtask

   // apply the currently driven inputs to the model, then clock once
   task automatic tick();
      int a;
      logic [7:0] old_acc, src, st;
      bit put, dput, iput;
      a = int'(bus.reg_addr);
      put = bus.write_put_acc;
      old_acc = m_acc[m_bank];
      src = bus.read_get_to_acc ? m_read(a) : bus.acc_in;
      st = m_st[m_bank];
      dput = put && (a == 9 || a == 10);
      iput = put && (a == 11 || a == 12);
      if (put) begin
         if (a < 8)        m_gpr[m_bank][a] = old_acc;
         else if (a == 9)  m_dptr = (old_acc % 16) * 256 + m_dptr % 256;
         else if (a == 10) m_dptr = (m_dptr / 256) * 256 + old_acc;
         else if (a == 11) m_iptr = (old_acc % 16) * 256 + m_iptr % 256;
         else if (a == 12) m_iptr = (m_iptr / 256) * 256 + old_acc;
         else if (a == 13) st = old_acc;
      end
      if (bus.status_write_enable)
         st = {st[7:4], bus.overflow_flag, bus.carry_flag, bus.positive_flag, bus.zero_flag};
      m_st[m_bank] = st;
      if (bus.acc_write_enable) m_acc[m_bank] = src;
      if (bus.dptr_inc && !dput) m_dptr = (m_dptr + 1) % 4096;
      if (bus.iptr_inc && !iput) m_iptr = (m_iptr + 1) % 4096;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic chk_rd(input int a);
      rexp_t e;
      bus.rd_b_addr = 4'(a); bus.reg_addr = 4'(a); bus.read_data_output_enable = 1;
      e.addr = a; e.d = m_read(a); e.acc = m_acc[m_bank];
      e.dm = 12'(m_dptr); e.im = 12'(m_iptr); e.bank = 2'(m_bank);
      rq.push_back(e);
      chk_vld = 1'b1;
      tick();
      chk_vld = 1'b0;
   endtask

   task automatic set_acc(input logic [7:0] v);
      bus.acc_in = v; bus.acc_write_enable = 1; tick();
   endtask

   task automatic put(input int a);
      bus.write_put_acc = 1; bus.reg_addr = 4'(a); tick();
   endtask

   task automatic do_ctx(input int bank, input bit copy);
      aexp_t e;
      bit err, sw;
      err = (bank >= NB);
      sw = !err && (bank != m_bank);
      e.err = err; e.bank = 2'(sw ? bank : m_bank); e.cyc = cyc + 1 + (sw ? 1 : 0);
      aq.push_back(e);
      bus.ctx_req = 1; bus.ctx_bank = 2'(bank); bus.ctx_copy_acc = copy;
      tick();
      if (sw) begin
         if (copy) m_acc[bank] = m_acc[m_bank];
         tick();
         m_bank = bank;
      end
      tick();
   endtask

   always @(negedge clk) begin
      if (bus.ctx_ack) begin
         if (aq.size() == 0) cmp("unexpected_ack", 32'(bus.ctx_ack), 32'd0);
         else begin
            aexp_t e;
            e = aq.pop_front();
            cmp("ack_cycle", 32'(cyc), 32'(e.cyc));
            cmp("ctx_err", 32'(bus.ctx_err), 32'(e.err));
            cmp("ack_bank", 32'(bus.cur_bank), 32'(e.bank));
         end
      end
      if (chk_vld) begin
         if (rq.size() == 0) cmp("read_queue_empty", 32'd1, 32'd0);
         else begin
            rexp_t e;
            e = rq.pop_front();
            cmp($sformatf("rd_b[%0d]", e.addr), 32'(bus.rd_b_data), 32'(e.d));
            cmp($sformatf("read_data[%0d]", e.addr), 32'(read_data), 32'(e.d));
            cmp("acc_out", 32'(bus.acc_out), 32'(e.acc));
            cmp("dmar", 32'(bus.dmar), 32'(e.dm));
            cmp("imar", 32'(bus.imar), 32'(e.im));
            cmp("cur_bank", 32'(bus.cur_bank), 32'(e.bank));
            cmp("ctx_ready", 32'(bus.ctx_ready), 32'd1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      m_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int a = 0; a < 16; a++) chk_rd(a);

      // bank isolation of GPRs
      set_acc(8'h5A); put(3); chk_rd(3);
      do_ctx(1, 0); chk_rd(3);
      do_ctx(0, 0); chk_rd(3);

      // pointer wrap, carry and PUT-over-increment
      set_acc(8'h0F); put(9);
      set_acc(8'hFF); put(10); chk_rd(9);
      bus.dptr_inc = 1; tick(); chk_rd(10);
      put(10); bus.dptr_inc = 1; tick(); chk_rd(9);
      set_acc(8'h37); bus.write_put_acc = 1; bus.reg_addr = 4'd10; bus.dptr_inc = 1; tick();
      chk_rd(10);

      // ACC copy on switch, old bank preserved
      set_acc(8'h21); do_ctx(1, 1); chk_rd(8);
      do_ctx(0, 0); chk_rd(8);

      // PUT STATUS with simultaneous flag update
      set_acc(8'hF0);
      bus.write_put_acc = 1; bus.reg_addr = 4'd13; bus.status_write_enable = 1;
      bus.zero_flag = 0; bus.positive_flag = 0; bus.carry_flag = 1; bus.overflow_flag = 1;
      tick(); chk_rd(13);

      // rejected and no-op requests
      do_ctx(3, 0); chk_rd(14);
      do_ctx(0, 1); chk_rd(14);

      // reset in the middle of a switch
      do_ctx(2, 0); set_acc(8'h44); chk_rd(8);
      bus.ctx_req = 1; bus.ctx_bank = 2'd1; tick();
      reset_n = 1'b0; #2; reset_n = 1'b1;
      m_reset();
      tick(); chk_rd(14); chk_rd(8); chk_rd(13);

      repeat (500) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) do_ctx($urandom_range(0, 3), 1'($urandom_range(0, 1)));
         else if (r < 3) chk_rd($urandom_range(0, 15));
         else begin
            bus.acc_in = 8'($urandom); bus.acc_write_enable = 1'($urandom_range(0, 1));
            bus.read_get_to_acc = 1'($urandom_range(0, 1));
            bus.write_put_acc = 1'($urandom_range(0, 1)); bus.reg_addr = 4'($urandom_range(0, 15));
            bus.status_write_enable = 1'($urandom_range(0, 1));
            bus.zero_flag = 1'($urandom); bus.positive_flag = 1'($urandom);
            bus.carry_flag = 1'($urandom); bus.overflow_flag = 1'($urandom);
            bus.dptr_inc = 1'($urandom_range(0, 1)); bus.iptr_inc = 1'($urandom_range(0, 1));
            tick();
         end
      end

      tick(); tick();
      cmp("pending_acks", 32'(aq.size()), 32'd0);
      cmp("pending_reads", 32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
